i2s_tx: RTL and testbench
=========================

// Module: i2s_tx
// PURPOSE
// - I2S transmitter: the output-side counterpart of the mic i2s receiver. Serializes 16-bit stereo
//   samples to an external I2S DAC/amp at 48 kHz. Generates its own BCLK (3.072 MHz) and LRCLK
//   (48 kHz) from the 98.3 MHz audio_clk domain. Sits between the audio processing path and pmod pins.
// PARAMETERS
// - SAMPLE_WIDTH   16  bits per channel sample, sent MSB first
// - BCLK_DIV_LOG2  5   BCLK period = 2^BCLK_DIV_LOG2 clk_in cycles (32 -> 3.072 MHz)
// - SLOT_BITS      32  BCLK periods per channel slot; frame = 2*SLOT_BITS (64 -> 48 kHz)
// PORTS
// - clk_in            in   1   audio_clk, 98.3 MHz; only clock
// - rst_in            in   1   synchronous, active-high reset
// - left_in           in   16  left sample, signed two's complement
// - right_in          in   16  right sample, signed two's complement
// - sample_valid_in   in   1   left_in/right_in valid
// - sample_ready_out  out  1   block can accept a sample pair this cycle
// - i2s_bclk_out      out  1   serial bit clock
// - i2s_lrclk_out     out  1   word select: 0 = left slot, 1 = right slot
// - i2s_data_out      out  1   serial data, changes only on BCLK falling edge
// - frame_start_out   out  1   1-cycle pulse, coincident with LRCLK falling (new frame)
// - underrun_out      out  1   1-cycle pulse, with frame_start_out, when no sample was pending
// BEHAVIOUR
// - Clocking: div_cnt[4:0] free-runs; i2s_bclk_out = div_cnt[4] (low for counts 0-15, high 16-31).
//   "Tick" = cycle with div_cnt==31; BCLK falls on the following edge. bit_cnt[5:0] counts 0..63,
//   increments (mod 64) on each tick. LRCLK, data, frame_start, underrun registered on the tick so they
//   change on the same clk_in edge as BCLK falling; never glitch mid-period.
// - Slot format (Philips I2S, one-BCLK delay): lrclk = 0 for bit_cnt 0..31, 1 for 32..63.
//   data at bit_cnt n: n=1..16 -> L[16-n]; n=33..48 -> R[48-n]; all other n -> 0.
//   Receiver samples on BCLK rising edge, mid-bit.
// - Buffering: one-entry pending register {L,R}. sample_ready_out = !pending_valid && !rst_in
//   (combinational). Transfer when valid && ready; pending_valid <= 1.
// - Frame load: on tick with bit_cnt==63: if pending_valid, active shift regs <= pending,
//   pending_valid <= 0; else active <= 0 and underrun_out pulses. frame_start_out pulses every frame.
//   Load uses pending state at start of cycle: a transfer in the load cycle itself (pending was
//   empty) is stored in pending for the NEXT frame; current frame underruns. No bypass path.
// - Latency: sample accepted while pending empty appears at next frame boundary; MSB on line
//   one BCLK (32 clk_in) after LRCLK falls.
// - Reset (sync): div_cnt=0, bit_cnt=0, active regs=0, pending_valid=0. Outputs next edge: bclk=0,
//   lrclk=0, data=0, frame_start=0, underrun=0; ready=0 while rst_in high, 1 the cycle after release.
//   First frame after reset is all zeros; no frame_start/underrun pulse for it (next boundary at
//   first bit_cnt 63->0 tick). Reset mid-frame: pending sample discarded, frame aborted, timing restarts.
// - Width: samples passed through unmodified; no saturation, no sign handling beyond bit order.
// TESTING
// - Reset: rst_in high 3 cycles mid-frame -> bclk/lrclk/data/pulses 0, ready 0; release -> ready 1
//   next cycle, bclk first rises 16 cycles after release, pending discarded.
// - Timing: free-run 3 frames -> bclk period 32 cycles 50% duty; lrclk period 2048 cycles, 1024 low;
//   every lrclk/data edge coincides with a bclk falling edge; frame_start period 2048.
// - Data: L=16'hA5C3, R=16'h8001 one cycle -> captured on bclk rising: bits1-16=1010010111000011,
//   bits33-48=1000000000000001, all other 32 bits 0; underrun_out 0 for that frame.
// - Backpressure: valid held high with 3 pairs P0,P1,P2 -> P0 accepted, ready low until frame load,
//   then P1 accepted; frames carry P0,P1,P2 in order, no drops or duplicates.
// - Underrun: no samples for 2 frames -> data all 0, underrun_out pulses with each frame_start.
// - Load-cycle race: valid asserted only in tick cycle with bit_cnt==63, pending empty ->
//   underrun pulse, that frame zero, sample transmitted in following frame.

Source files
------------

// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S stereo transmitter with self-generated BCLK/LRCLK and a one-entry sample buffer
module i2s_tx #(
  parameter int SAMPLE_WIDTH  = 16,
  parameter int BCLK_DIV_LOG2 = 5,
  parameter int SLOT_BITS     = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [SAMPLE_WIDTH-1:0] left_in,
  input  logic [SAMPLE_WIDTH-1:0] right_in,
  input  logic                    sample_valid_in,
  output logic                    sample_ready_out,
  output logic                    i2s_bclk_out,
  output logic                    i2s_lrclk_out,
  output logic                    i2s_data_out,
  output logic                    frame_start_out,
  output logic                    underrun_out
);
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam int PW = BW - 1;
  localparam int IW = $clog2(SAMPLE_WIDTH);
  logic [BCLK_DIV_LOG2-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d, nxt;
  logic [PW-1:0] pos;
  logic [IW-1:0] idx;
  logic [SAMPLE_WIDTH-1:0] pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [SAMPLE_WIDTH-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic pend_v_q, pend_v_d, lr_q, lr_d, data_q, data_d, fs_q, fs_d, ur_q, ur_d;
  logic tick, load, accept, in_slot;
  assign sample_ready_out = !pend_v_q && !rst_in;
  assign i2s_bclk_out     = div_q[BCLK_DIV_LOG2-1];
  assign i2s_lrclk_out    = lr_q;
  assign i2s_data_out     = data_q;
  assign frame_start_out  = fs_q;
  assign underrun_out     = ur_q;
  always_comb begin
    tick     = &div_q;
    load     = tick && (&bit_q);
    accept   = sample_valid_in && sample_ready_out;
    nxt      = bit_q + BW'(1);
    pos      = nxt[PW-1:0];
    idx      = IW'(SAMPLE_WIDTH - 1) - IW'(pos - PW'(1));
    in_slot  = pos != '0 && pos <= PW'(SAMPLE_WIDTH);
    div_d    = div_q + BCLK_DIV_LOG2'(1);
    bit_d    = tick ? nxt : bit_q;
    pend_v_d = accept || (pend_v_q && !load);
    pend_l_d = accept ? left_in : pend_l_q;
    pend_r_d = accept ? right_in : pend_r_q;
    act_l_d  = load ? (pend_v_q ? pend_l_q : '0) : act_l_q;
    act_r_d  = load ? (pend_v_q ? pend_r_q : '0) : act_r_q;
    lr_d     = tick ? nxt[BW-1] : lr_q;
    data_d   = tick ? in_slot && (nxt[BW-1] ? act_r_q[idx] : act_l_q[idx]) : data_q;
    fs_d     = load;
    ur_d     = load && !pend_v_q;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_q    <= '0;
      bit_q    <= '0;
      pend_v_q <= 1'b0;
      pend_l_q <= '0;
      pend_r_q <= '0;
      act_l_q  <= '0;
      act_r_q  <= '0;
      lr_q     <= 1'b0;
      data_q   <= 1'b0;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      bit_q    <= bit_d;
      pend_v_q <= pend_v_d;
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      act_l_q  <= act_l_d;
      act_r_q  <= act_r_d;
      lr_q     <= lr_d;
      data_q   <= data_d;
      fs_q     <= fs_d;
      ur_q     <= ur_d;
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed self-checking bench for i2s_tx
module tb_i2s_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] l = '0;
  logic [15:0] r = '0;
  logic valid = 1'b0;
  logic ready, bclk, lrclk, data, fs, ur;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  i2s_tx dut (
    .clk_in(clk),
    .rst_in(rst),
    .left_in(l),
    .right_in(r),
    .sample_valid_in(valid),
    .sample_ready_out(ready),
    .i2s_bclk_out(bclk),
    .i2s_lrclk_out(lrclk),
    .i2s_data_out(data),
    .frame_start_out(fs),
    .underrun_out(ur)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask
  task automatic frame_chk(input string tag, input int base, input logic [15:0] el, input logic [15:0] er);
    logic [63:0] d, lr, bc;
    for (int n = 0; n < 64; n++) begin
      goto(base + 32 * n + 16);
      d[63-n]  = data;
      lr[63-n] = lrclk;
      bc[63-n] = bclk;
    end
    chk({tag, "_data"}, d, {1'b0, el, 15'b0, 1'b0, er, 15'b0});
    chk({tag, "_lrclk"}, lr, {32'h0, 32'hFFFF_FFFF});
    chk({tag, "_bclk_mid"}, bc, {64{1'b1}});
  endtask
  task automatic boundary(input string tag, input logic exp_ur);
    goto(cyc - cyc % 2048 + 2047);
    chk({tag, "_fs_pre"}, {63'b0, fs}, 64'd0);
    chk({tag, "_bclk_pre"}, {63'b0, bclk}, 64'd1);
    goto(cyc + 1);
    chk({tag, "_fs"}, {63'b0, fs}, 64'd1);
    chk({tag, "_ur"}, {63'b0, ur}, {63'b0, exp_ur});
    chk({tag, "_bclk_fall"}, {63'b0, bclk}, 64'd0);
    chk({tag, "_lrclk_fall"}, {63'b0, lrclk}, 64'd0);
    goto(cyc + 1);
    chk({tag, "_fs_pulse"}, {63'b0, fs}, 64'd0);
    chk({tag, "_ur_pulse"}, {63'b0, ur}, 64'd0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {59'b0, bclk, lrclk, data, fs, ur}, 64'd0);
    chk("rst_ready", {63'b0, ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", {63'b0, ready}, 64'd1);
    l = 16'hA5C3;
    r = 16'h8001;
    valid = 1'b1;
    goto(1);
    valid = 1'b0;
    chk("acc_ready", {63'b0, ready}, 64'd0);
    goto(15);
    chk("bclk_15", {63'b0, bclk}, 64'd0);
    goto(16);
    chk("bclk_16", {63'b0, bclk}, 64'd1);
    frame_chk("f0_zero", 0, 16'h0, 16'h0);
    boundary("b1", 1'b0);
    chk("b1_ready", {63'b0, ready}, 64'd1);
    frame_chk("f1_a5c3", 2048, 16'hA5C3, 16'h8001);
    boundary("b2", 1'b1);
    frame_chk("f2_under", 4096, 16'h0, 16'h0);
    boundary("b3", 1'b1);
    goto(6150);
    l = 16'h0001;
    r = 16'h8000;
    valid = 1'b1;
    goto(6151);
    chk("p0_acc", {63'b0, ready}, 64'd0);
    l = 16'hFFFF;
    r = 16'h0000;
    goto(8191);
    chk("p1_wait", {63'b0, ready}, 64'd0);
    goto(8192);
    chk("p1_load_ready", {63'b0, ready}, 64'd1);
    chk("b4_ur", {63'b0, ur}, 64'd0);
    goto(8193);
    chk("p1_acc", {63'b0, ready}, 64'd0);
    l = 16'h5A5A;
    r = 16'hC3C3;
    frame_chk("f4_p0", 8192, 16'h0001, 16'h8000);
    goto(10240);
    chk("p2_load_ready", {63'b0, ready}, 64'd1);
    chk("b5_ur", {63'b0, ur}, 64'd0);
    goto(10241);
    valid = 1'b0;
    chk("p2_acc", {63'b0, ready}, 64'd0);
    frame_chk("f5_p1", 10240, 16'hFFFF, 16'h0000);
    boundary("b6", 1'b0);
    frame_chk("f6_p2", 12288, 16'h5A5A, 16'hC3C3);
    boundary("b7", 1'b1);
    goto(16383);
    chk("race_ready", {63'b0, ready}, 64'd1);
    l = 16'h1234;
    r = 16'hFEDC;
    valid = 1'b1;
    goto(16384);
    valid = 1'b0;
    chk("race_fs", {63'b0, fs}, 64'd1);
    chk("race_ur", {63'b0, ur}, 64'd1);
    chk("race_pend", {63'b0, ready}, 64'd0);
    frame_chk("f8_race_zero", 16384, 16'h0, 16'h0);
    boundary("b9", 1'b0);
    frame_chk("f9_race", 18432, 16'h1234, 16'hFEDC);
    goto(20490);
    l = 16'hBEEF;
    r = 16'h1357;
    valid = 1'b1;
    goto(20491);
    valid = 1'b0;
    goto(21848);
    chk("mid_pend", {63'b0, ready}, 64'd0);
    chk("mid_lr_bclk", {62'b0, lrclk, bclk}, 64'd3);
    rst = 1'b1;
    goto(21849);
    chk("mid_rst_outs", {59'b0, bclk, lrclk, data, fs, ur}, 64'd0);
    chk("mid_rst_ready", {63'b0, ready}, 64'd0);
    goto(21851);
    rst = 1'b0;
    cyc = 0;
    #1;
    chk("mid_rel_ready", {63'b0, ready}, 64'd1);
    goto(15);
    chk("mid_bclk_15", {63'b0, bclk}, 64'd0);
    goto(16);
    chk("mid_bclk_16", {63'b0, bclk}, 64'd1);
    frame_chk("mid_f0_zero", 0, 16'h0, 16'h0);
    boundary("mid_b1", 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
